// File: rtl/digest_p2s.sv
// -----------------------------------------------------------------------------
// digest_p2s
//   Parallel-to-serial streamer. A WIDTH_IN-bit value (normally an MD5 digest)
//   is loaded in one cycle. It is then emitted as WIDTH_IN/WIDTH_OUT words over
//   a valid/ready handshake to a byte consumer such as a UART transmitter.
//
// Handshake: a word transfers at a rising edge where out_valid=1 and
//   out_ready=1. While out_valid=1 and out_ready=0, d_out, out_valid and
//   words_left are held stable. out_valid never depends combinationally on
//   out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   load       capture d_in and start streaming (accepted in IDLE or DONE)
//   abort      cancel an in-progress stream (SEND only)
//   d_in       parallel data, sampled only on an accepted load
//   d_out      current output word (0 in IDLE)
//   out_valid  d_out holds a valid word
//   out_ready  consumer accepts d_out this cycle
//   busy       stream in progress
//   done       one-cycle pulse after the last word is transferred
//   words_left words not yet transferred
//   dbg_state  current FSM state (0=IDLE, 1=SEND, 2=DONE)
// -----------------------------------------------------------------------------
module digest_p2s #(
  parameter int WIDTH_IN  = 128,
  parameter int WIDTH_OUT = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        load,
  input  logic                                        abort,
  input  logic [WIDTH_IN-1:0]                         d_in,
  output logic [WIDTH_OUT-1:0]                        d_out,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        busy,
  output logic                                        done,
  output logic [$clog2(WIDTH_IN/WIDTH_OUT):0]         words_left,
  output logic [1:0]                                  dbg_state
);

  localparam int WL_W = $clog2(WIDTH_IN/WIDTH_OUT) + 1;
  localparam logic [WL_W-1:0] N_WORDS = WL_W'(WIDTH_IN / WIDTH_OUT);
  localparam logic [WL_W-1:0] ONE     = WL_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH_IN-1:0]  r_shift;
  logic [WIDTH_IN-1:0]  w_shift_nxt;
  logic [WIDTH_IN-1:0]  w_shift_adv;
  logic [WL_W-1:0]      r_words;
  logic [WL_W-1:0]      w_words_nxt;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_valid_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 w_xfer;

  // r_valid is only ever set in SEND, so this is the transfer condition.
  assign w_xfer = r_valid & out_ready;

  // Vacated bits fill with zero, so the register is all-zero once the last
  // word has been shifted out and d_out reads 0 afterwards.
  assign w_shift_adv = (MSB_FIRST != 0) ? (r_shift << WIDTH_OUT)
                                        : (r_shift >> WIDTH_OUT);

  // State register and all output/data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_words <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_words <= w_words_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic. Load wins over abort in IDLE/DONE; abort wins over a
  // coincident transfer in SEND; load in SEND is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_state_nxt = load ? S_SEND : S_IDLE;
      S_SEND: begin
        if (abort)                         w_state_nxt = S_IDLE;
        else if (w_xfer && r_words == ONE) w_state_nxt = S_DONE;
        else                               w_state_nxt = S_SEND;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: computes the values the output registers take next cycle,
  // keeping every port a pure register output.
  always_comb begin
    w_shift_nxt = r_shift;
    w_words_nxt = r_words;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (load) begin
          w_shift_nxt = d_in;
          w_words_nxt = N_WORDS;
        end else begin
          w_shift_nxt = '0;
          w_words_nxt = '0;
        end
      end
      S_SEND: begin
        if (abort) begin
          w_shift_nxt = '0;
          w_words_nxt = '0;
        end else if (w_xfer) begin
          w_shift_nxt = w_shift_adv;
          w_words_nxt = r_words - ONE;
        end
      end
      default: begin
        w_shift_nxt = '0;
        w_words_nxt = '0;
      end
    endcase
    w_valid_nxt = (w_state_nxt == S_SEND);
    w_busy_nxt  = (w_state_nxt == S_SEND);
    w_done_nxt  = (w_state_nxt == S_DONE);
  end

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign d_out = r_shift[WIDTH_IN-1 -: WIDTH_OUT];
    end else begin : g_lsb
      assign d_out = r_shift[WIDTH_OUT-1:0];
    end
  endgenerate

  assign out_valid  = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign words_left = r_words;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_digest_p2s.sv
module tb_digest_p2s;
  localparam int WI = 128;
  localparam int WO = 8;
  localparam int NW = WI / WO;
  localparam logic [127:0] D_STD = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           load;
  logic           abort;
  logic           out_ready;
  logic [WI-1:0]  d_in;

  logic [WO-1:0]  m_dout, l_dout;
  logic           m_valid, l_valid, m_busy, l_busy, m_done, l_done;
  logic [4:0]     m_wl, l_wl;
  logic [1:0]     m_dbg, l_dbg;

  digest_p2s #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .load(load), .abort(abort), .d_in(d_in),
    .d_out(m_dout), .out_valid(m_valid), .out_ready(out_ready),
    .busy(m_busy), .done(m_done), .words_left(m_wl), .dbg_state(m_dbg));

  digest_p2s #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load(load), .abort(abort), .d_in(d_in),
    .d_out(l_dout), .out_valid(l_valid), .out_ready(out_ready),
    .busy(l_busy), .done(l_done), .words_left(l_wl), .dbg_state(l_dbg));

  // ---------------- scoreboard / reference model ----------------
  int tests = 0;
  int fails = 0;
  logic [WO-1:0] exp_msb_q[$];
  logic [WO-1:0] exp_lsb_q[$];
  logic          exp_done = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream model: an accepted load queues every word of d_in in emission
  // order; a transfer pops one; abort empties the queue.
  task automatic model_update();
    logic          active;
    logic          nd;
    logic [127:0]  tmp;
    active = (exp_msb_q.size() > 0);
    nd = 1'b0;
    if (!rst_n) begin
      exp_msb_q.delete();
      exp_lsb_q.delete();
    end else if (!active) begin
      if (load) begin
        for (int k = 0; k < NW; k++) begin
          tmp = d_in >> (WI - WO * (k + 1));
          exp_msb_q.push_back(tmp[WO-1:0]);
          tmp = d_in >> (WO * k);
          exp_lsb_q.push_back(tmp[WO-1:0]);
        end
      end
    end else if (abort) begin
      exp_msb_q.delete();
      exp_lsb_q.delete();
    end else if (out_ready) begin
      void'(exp_msb_q.pop_front());
      void'(exp_lsb_q.pop_front());
      if (exp_msb_q.size() == 0) nd = 1'b1;
    end
    exp_done = nd;
  endtask

  task automatic check_all();
    int n;
    n = exp_msb_q.size();
    check("m_valid", m_valid, n > 0);
    check("l_valid", l_valid, n > 0);
    check("m_busy",  m_busy,  n > 0);
    check("l_busy",  l_busy,  n > 0);
    check("m_done",  m_done,  exp_done);
    check("l_done",  l_done,  exp_done);
    check("m_words_left", m_wl, n);
    check("l_words_left", l_wl, n);
    if (n > 0) begin
      check("m_dout", m_dout, exp_msb_q[0]);
      check("l_dout", l_dout, exp_lsb_q[0]);
    end else if (!exp_done) begin
      check("m_dout_idle", m_dout, 0);
      check("l_dout_idle", l_dout, 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_done(input string tag, input int budget, output int n);
    n = 0;
    while (!exp_done && n < budget) begin
      step();
      n++;
    end
    if (!exp_done) begin
      tests++;
      fails++;
      $error("FAIL %s_timeout observed=%0d cycles expected=done", tag, n);
    end
  endtask

  task automatic start(input logic [127:0] d);
    d_in = d;
    load = 1'b1;
    step();
    load = 1'b0;
    d_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0; load = 1'b0; abort = 1'b0; out_ready = 1'b1; d_in = '0;
    #3;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_dout", m_dout, 0);
    check("rst_m_wl", m_wl, 0);
    check("rst_m_state", m_dbg, 0);
    check("rst_l_state", l_dbg, 0);
    steps(2);
    rst_n = 1'b1;
    d_in = {$urandom, $urandom, $urandom, $urandom};
    steps(3);

    // Full stream, out_ready held high
    start(D_STD);
    check("t1_first_m", m_dout, 8'h00);
    check("t1_first_l", l_dout, 8'hFF);
    check("t1_first_wl", m_wl, 16);
    run_to_done("t1", 40, n);
    check("t1_len", n, 16);
    check("t1_done_busy", m_busy, 0);
    steps(2);

    // Backpressure on word 0x33
    start(D_STD);
    n = 0;
    while (exp_msb_q.size() > 0 && exp_msb_q[0] != 8'h33 && n < 20) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_dout", m_dout, 8'h33);
      check("bp_hold_wl", m_wl, 13);
      check("bp_hold_valid", m_valid, 1);
    end
    out_ready = 1'b1;
    step();
    check("bp_next", m_dout, 8'h44);
    run_to_done("bp", 40, n);
    check("bp_len", n + 7, 19);

    // Load while busy, then back-to-back load in the done cycle
    start(D_STD);
    steps(4);
    d_in = {16{8'hAA}};
    load = 1'b1;
    step();
    load = 1'b0;
    run_to_done("lwb", 40, n);
    check("lwb_len", n + 5, 16);
    d_in = {16{8'h55}};
    load = 1'b1;
    step();
    load = 1'b0;
    check("b2b_dout", m_dout, 8'h55);
    check("b2b_wl", m_wl, 16);
    check("b2b_busy", m_busy, 1);
    run_to_done("b2b", 40, n);
    steps(2);

    // Abort at word 7
    start(D_STD);
    steps(6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", m_valid, 0);
    check("abort_busy", m_busy, 0);
    steps(3);

    // Abort coincident with the last transfer
    start(D_STD);
    steps(15);
    check("abort_last_pre", m_dout, 8'hFF);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_last_done", m_done, 0);
    steps(2);

    // Abort in IDLE has no effect; load+abort together: load wins
    abort = 1'b1;
    step();
    load = 1'b1;
    d_in = D_STD;
    step();
    load = 1'b0;
    abort = 1'b0;
    check("la_valid", m_valid, 1);
    run_to_done("la", 40, n);
    steps(1);

    // Asynchronous reset mid-stream at word 9
    start(D_STD);
    steps(8);
    #2 rst_n = 1'b0;
    #1;
    exp_msb_q.delete();
    exp_lsb_q.delete();
    exp_done = 1'b0;
    check("arst_m_valid", m_valid, 0);
    check("arst_m_busy", m_busy, 0);
    check("arst_m_dout", m_dout, 0);
    check("arst_l_dout", l_dout, 0);
    check("arst_m_wl", m_wl, 0);
    check("arst_l_wl", l_wl, 0);
    steps(2);
    rst_n = 1'b1;
    steps(4);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      load      = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 40) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      d_in      = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    load = 1'b0; abort = 1'b0; out_ready = 1'b1;
    steps(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
